// File: rtl/impl_fold_arbiter.sv
// Purpose : round-robin arbiter in front of one shared implication-fold accumulator
//           (acc <= ~acc | operand, seeded with all-ones), returning {result, id}.
// Latency : 1 arbitration cycle, k beat cycles, result visible from cycle k+1.
//           Backpressure: only the granted requester sees ready; the result holds until res_ready_i.
// Ports   : clk/rst (sync, active-high); req_valid_i/req_data_i/req_last_i/req_ready_o per requester;
//           res_valid_o/res_data_o/res_id_o/res_ready_i result handshake; busy_o while not IDLE.
module impl_fold_arbiter #(
   parameter  int COUNT_OF_BITS = 4,
   parameter  int NUM_REQ       = 4,
   localparam int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   input  logic [NUM_REQ*COUNT_OF_BITS-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]               req_last_i,
   output logic [NUM_REQ-1:0]               req_ready_o,
   output logic                             res_valid_o,
   output logic [COUNT_OF_BITS-1:0]         res_data_o,
   output logic [ID_W-1:0]                  res_id_o,
   input  logic                             res_ready_i,
   output logic                             busy_o
);

   localparam int W   = COUNT_OF_BITS;
   localparam int IW1 = ID_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t              state_q;
   logic [W-1:0]        acc_q;
   logic [W-1:0]        acc_d;
   logic [ID_W-1:0]     grant_q;
   logic [ID_W-1:0]     rr_ptr_q;
   logic [NUM_REQ-1:0]  req_ready_q;
   logic                res_valid_q;
   logic                busy_q;

   logic                win_vld;
   logic [ID_W-1:0]     win_idx;
   logic [IW1-1:0]      cand;
   logic [NUM_REQ-1:0]  win_onehot;
   logic [W-1:0]        sel_dat;
   logic                sel_vld;
   logic                sel_last;

   // Round-robin search: candidates rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_REQ.
   // One extra bit on cand keeps rr_ptr+NUM_REQ from overflowing before the wrap.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + IW1'(i);
         if (cand >= IW1'(NUM_REQ)) begin
            cand = cand - IW1'(NUM_REQ);
         end
         if (!win_vld && req_valid_i[cand[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = cand[ID_W-1:0];
         end
      end
   end

   assign win_onehot = NUM_REQ'(1) << win_idx;

   // Operand mux for the granted requester; the single fold datapath follows it.
   always_comb begin
      sel_dat  = '0;
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            sel_dat  = req_data_i[i*W +: W];
            sel_vld  = req_valid_i[i];
            sel_last = req_last_i[i];
         end
      end
      acc_d = ~acc_q | sel_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '1;
         rr_ptr_q    <= ID_W'(NUM_REQ - 1);
         grant_q     <= '0;
         req_ready_q <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  grant_q     <= win_idx;
                  acc_q       <= '1;
                  req_ready_q <= win_onehot;
                  busy_q      <= 1'b1;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               // Ready is held on the granted port, so its valid alone marks a beat.
               if (sel_vld) begin
                  acc_q <= acc_d;
                  if (sel_last) begin
                     req_ready_q <= '0;
                     res_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            RESP: begin
               if (res_ready_i) begin
                  rr_ptr_q    <= grant_q;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = acc_q;
   assign res_id_o    = grant_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_impl_fold_arbiter.sv
module tb_impl_fold_arbiter;
   localparam int W   = 4;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic             res_valid;
   logic [W-1:0]     res_data;
   logic [IDW-1:0]   res_id;
   logic             res_ready;
   logic             busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   dat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int                  id;
      int                  n;
      logic [2:0][W-1:0]   ops;   // ops[0] is the first beat
      logic [W-1:0]        exp;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   impl_fold_arbiter #(.COUNT_OF_BITS(W), .NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .res_valid_o (res_valid),
      .res_data_o  (res_data),
      .res_id_o    (res_id),
      .res_ready_i (res_ready),
      .busy_o      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int id, input logic [W-1:0] dat);
      exp_t e;
      e.id  = IDW'(id);
      e.dat = dat;
      sb.push_back(e);
   endtask

   // Scoreboard: every accepted result is popped and compared.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 32'(res_valid), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_res_data", 32'(res_data), 32'(e.dat));
            chk("sb_res_id", 32'(res_id), 32'(e.id));
         end
      end
   end

   task automatic wait_res(output int c, output bit ok);
      ok = 1'b0;
      c  = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) chk("res_timeout", 32'(0), 32'(1));
   endtask

   // Waits for the result, checks latency and data, then lets the handshake edge pass.
   task automatic collect(input int c0, input int lat, input logic [W-1:0] exp_dat);
      int c;
      bit ok;
      wait_res(c, ok);
      if (ok) begin
         chk("job_latency", 32'(c - c0), 32'(lat));
         chk("job_data", 32'(res_data), 32'(exp_dat));
      end
      @(posedge clk); #1;
   endtask

   task automatic run_job(input int id, input int n, input logic [2:0][W-1:0] ops,
                          input logic [W-1:0] exp, output int c0);
      bit got, ok;
      push_exp(id, exp);
      @(posedge clk); #1;
      c0 = cyc;
      for (int b = 0; b < n; b++) begin
         req_valid = N'(1) << id;
         req_data  = '0;
         req_data[id*W +: W] = ops[b];
         req_last  = (b == n - 1) ? (N'(1) << id) : '0;
         ok = 1'b0;
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            got = req_ready[id];
            @(posedge clk); #1;
            if (got) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) chk("beat_timeout", 32'(0), 32'(1));
      end
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
   endtask

   // Requester 2: 0101 then 0011 (last) -> 1011, with optional operand gap and result backpressure.
   task automatic two_beat(input int gap, input int bp);
      int c0;
      push_exp(2, 4'b1011);
      @(posedge clk); #1;
      c0 = cyc;
      res_ready = (bp == 0);
      req_valid = 4'b0100;
      req_data  = 16'h0500;
      req_last  = 4'b0000;
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("run_ready1", 32'(req_ready), 32'(4'b0100));
      chk("acc_init", 32'(res_data), 32'(4'hF));
      @(posedge clk); #1;
      req_valid = 4'b0000;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         chk("gap_ready", 32'(req_ready), 32'(4'b0100));
         chk("gap_acc", 32'(res_data), 32'(4'b0101));
         chk("gap_no_res", 32'(res_valid), 32'(0));
         @(posedge clk); #1;
      end
      req_valid = 4'b0100;
      req_data  = 16'h0300;
      req_last  = 4'b0100;
      @(negedge clk);
      chk("run_ready2", 32'(req_ready), 32'(4'b0100));
      chk("acc_mid", 32'(res_data), 32'(4'b0101));
      @(posedge clk); #1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      @(negedge clk);
      chk("res_valid", 32'(res_valid), 32'(1));
      chk("res_latency", 32'(cyc - c0), 32'(3 + gap));
      chk("res_data", 32'(res_data), 32'(4'b1011));
      chk("res_id", 32'(res_id), 32'(2));
      chk("resp_ready", 32'(req_ready), 32'(0));
      if (bp > 0) begin
         for (int i = 1; i < bp; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", 32'(res_valid), 32'(1));
            chk("bp_data", 32'(res_data), 32'(4'b1011));
            chk("bp_id", 32'(res_id), 32'(2));
            chk("bp_ready", 32'(req_ready), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
         end
         @(posedge clk); #1;
         res_ready = 1'b1;
         @(negedge clk);
         chk("bp_release_valid", 32'(res_valid), 32'(1));
         chk("bp_release_data", 32'(res_data), 32'(4'b1011));
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("after_busy", 32'(busy), 32'(0));
      chk("after_valid", 32'(res_valid), 32'(0));
   endtask

   initial begin
      int c, c0, prev;
      bit ok;

      // Hand-computed expectations of acc <= ~acc | x starting from 1111.
      vecs[0] = '{0, 1, {4'h0, 4'h0, 4'hA}, 4'hA};
      vecs[1] = '{3, 2, {4'h0, 4'b0011, 4'b0101}, 4'b1011};
      vecs[2] = '{1, 3, {4'b1010, 4'b0000, 4'b1111}, 4'b1111};
      vecs[3] = '{2, 3, {4'b0000, 4'b0000, 4'b0000}, 4'b0000};
      vecs[4] = '{3, 1, {4'h0, 4'h0, 4'b0000}, 4'b0000};
      vecs[5] = '{0, 2, {4'h0, 4'b0110, 4'b1100}, 4'b0111};
      vecs[6] = '{1, 2, {4'h0, 4'b1000, 4'b0000}, 4'b1111};
      vecs[7] = '{2, 3, {4'b0010, 4'b0100, 4'b1001}, 4'b1011};

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_state", 32'({res_valid, req_ready, busy, res_data}),
             32'({1'b0, 4'b0000, 1'b0, 4'b1111}));
         @(posedge clk); #1;
      end

      two_beat(0, 0);   // gap-free two-beat job
      two_beat(3, 0);   // operand stall of 3 cycles
      two_beat(0, 5);   // result held for 5 cycles

      // Fairness: requesters 0 and 1 always valid with one-beat jobs.
      push_exp(0, 4'b0110);
      push_exp(1, 4'b1001);
      push_exp(0, 4'b0110);
      push_exp(1, 4'b1001);
      res_ready = 1'b1;
      req_valid = 4'b0011;
      req_last  = 4'b0011;
      req_data  = 16'h0096;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_res(c, ok);
         if (ok) begin
            chk("rr_id", 32'(res_id), 32'(k % 2));
            chk("rr_data", 32'(res_data), (k % 2 == 0) ? 32'(4'b0110) : 32'(4'b1001));
            if (k > 0) chk("rr_interval", 32'(c - prev), 32'(3));
            prev = c;
         end
         @(posedge clk); #1;
         if (k == 3) begin
            req_valid = '0;
            req_last  = '0;
            req_data  = '0;
         end
      end

      for (int v = 0; v < 8; v++) begin
         run_job(vecs[v].id, vecs[v].n, vecs[v].ops, vecs[v].exp, c0);
         collect(c0, vecs[v].n + 1, vecs[v].exp);
      end

      // Reset mid-job: requester 1 sends 0000, reset arrives with its last beat.
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_data  = 16'h0000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_ready", 32'(req_ready), 32'(4'b0010));
      @(posedge clk); #1;
      rst      = 1'b1;
      req_last = 4'b0010;
      @(negedge clk);
      chk("mid_acc", 32'(res_data), 32'(4'b0000));
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_acc", 32'(res_data), 32'(4'b1111));
      chk("mid_rst_ready", 32'(req_ready), 32'(0));
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_no_res", 32'(res_valid), 32'(0));
         @(posedge clk); #1;
         @(negedge clk);
      end
      run_job(1, 1, {4'h0, 4'h0, 4'b1100}, 4'b1100, c0);
      collect(c0, 2, 4'b1100);

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/impl_fold_arbiter.md
# impl_fold_arbiter

Shared implication-fold engine with a round-robin front end. Up to NUM_REQ requesters each submit a job: a stream of operands closed by a `last` beat. The block grants one requester at a time and folds that requester's operands through a single accumulator, using `acc <= ~acc | num` with the accumulator starting at all-ones. It then returns the final accumulator value with the requester's id. It sits between the operand sources and the consumer of fold results, so the fold datapath exists exactly once in the design.

## Interface
- COUNT_OF_BITS, 4, operand and result width W
- NUM_REQ, 4, number of requesters, legal range 2..8; ID_W = $clog2(NUM_REQ)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*W  per-requester operand; requester i occupies bits [i*W +: W]
- req_last  in  NUM_REQ  marks the final operand of a job
- req_ready  out  NUM_REQ  per-requester operand accept; one-hot or zero
- res_valid  out  1  result available
- res_data  out  W  fold result; always equals the internal acc
- res_id  out  ID_W  index of the requester that owns the result
- res_ready  in  1  consumer accepts the result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE
  - req_ready = 0 and res_valid = 0.
  - If any req_valid is set, pick the winner round-robin: search starts at rr_ptr+1 and wraps modulo NUM_REQ.
  - Latch grant = winner, load acc = all-ones, go to RUN.
  - Data is not consumed in IDLE; arbitration costs one cycle.
- RUN
  - req_ready[grant] = req_valid-independent 1; every other bit is 0.
  - On each req_valid[grant] & req_ready[grant] beat: acc <= ~acc | req_data[grant].
  - If req_last[grant] is set on that beat, go to RESP.
  - A cycle without valid stalls the job. acc holds and there is no timeout.
- RESP
  - res_valid = 1, res_data = acc, res_id = grant, req_ready = 0.
  - On res_ready: rr_ptr <= grant, go to IDLE.
  - res_data and res_id stay stable while res_valid & !res_ready.
- Arithmetic: bitwise, width W, no carries. A single-beat job returns its operand unchanged, because ~1…1 | x = x.
- Non-granted requesters are never acknowledged. They must hold valid and data until granted; the block stores nothing for them.
- req_last on a non-granted port, or sampled with valid low, has no effect.

## Timing
- Reset values:
  - state = IDLE, acc = all-ones, so res_data = all-ones.
  - rr_ptr = NUM_REQ-1, which gives requester 0 the highest priority first.
  - grant = 0, res_id = 0.
  - req_ready = 0, res_valid = 0, busy = 0.
- Job latency: request visible in IDLE at cycle 0.
  - RUN from cycle 1.
  - A k-beat job with no gaps transfers in cycles 1..k.
  - res_valid is high from cycle k+1.
- Back-to-back: a result handshake at cycle t returns to IDLE at t+1. The next grant's RUN starts at t+2.
- Throughput: a k-beat job occupies at least k+2 cycles.
- Reset in mid-job or in RESP:
  - The block goes to IDLE on the next edge and the partial or pending result is discarded.
  - acc returns to all-ones and rr_ptr returns to NUM_REQ-1.
- Reset has priority over every handshake in the same cycle.
- A requester that stays valid loses at most NUM_REQ-1 jobs to others before it is granted.

## Test plan
- Reset check: assert rst for 2 cycles, then release with no requests. Required: res_valid=0, req_ready=0000, busy=0, res_data=1111, held indefinitely.
- Single two-beat job: requester 2 sends 0101, then 0011 with last. Required:
  - req_ready=0100 in cycles 1..2.
  - res_valid at cycle 3 with res_data=1011 and res_id=2.
  - busy is low after res_ready.
- Round-robin fairness: requesters 0 and 1 both continuously valid with one-beat jobs (operands 0110 and 1001), res_ready=1. Required:
  - res_id sequence 0,1,0,1.
  - Results 0110 and 1001 respectively.
  - A new result every 3 cycles.
- Result backpressure: complete a job with result 1011, then hold res_ready=0 for 5 cycles. Required: res_valid, res_data=1011 and res_id stable; req_ready=0000 throughout; return to IDLE one cycle after res_ready.
- Operand stall: same job as the single two-beat job, with req_valid low for 3 cycles between the beats. Required: acc holds at 0101 during the gap; final result 1011, 3 cycles later than the gap-free case.
- Reset mid-job: requester 1 sends 0000, then rst fires before its last beat. Required:
  - busy=0 on the next cycle and no res_valid.
  - After restart, a one-beat job 1100 from requester 1 returns 1100, proving acc was reinitialised to 1111.
